// File: rtl/adc_daq_pipeline.sv
// Per-ADC-segment circular sample buffer with L1A-triggered readout of NSAMP words.
// Optional macro ADC_PIPE_PARITY_EN adds per-channel even parity storage and a sticky PAR_ERR flag.
module adc_daq_pipeline #(
    parameter int NSAMP    = 8,
    parameter int DEPTH_W  = 8,
    parameter int QDEPTH_W = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RESTART,
    input  logic [95:0]        DIN,
    input  logic [DEPTH_W-1:0] PDEPTH,
    input  logic               L1A,
    output logic [95:0]        DOUT,
    output logic               DVALID,
    output logic               PIPE_RDY,
    output logic               BUSY,
    output logic               OVFL,
    output logic [11:0]        EVT_CNT,
    output logic               PAR_ERR
);
    localparam int DEPTH   = 1 << DEPTH_W;
    localparam int QDEPTH  = 1 << QDEPTH_W;
    localparam int QCNT_W  = QDEPTH_W + 1;
    localparam int CNT_W   = $clog2(NSAMP + 1);
    localparam int PD_MIN  = NSAMP + 2;
    localparam int PD_MAX  = DEPTH - 5 * NSAMP;
`ifdef ADC_PIPE_PARITY_EN
    localparam int MEM_W   = 104;
`else
    localparam int MEM_W   = 96;
`endif

    typedef enum logic [1:0] {IDLE, FILL, RUN} wstate_t;
    typedef enum logic {RIDLE, READ} rstate_t;

    wstate_t              wstate;
    rstate_t              rstate;
    logic [DEPTH_W-1:0]   wptr, fill_cnt, pd_lat, raddr;
    logic [CNT_W-1:0]     rcnt;
    logic [MEM_W-1:0]     mem [DEPTH];
    logic [MEM_W-1:0]     rdata, wdata;
    logic [DEPTH_W-1:0]   q_mem [QDEPTH];
    logic [QDEPTH_W-1:0]  q_rd, q_wr;
    logic [QCNT_W-1:0]    q_cnt;
    logic                 rd_v, we, pop, push, full, trig;

    function automatic logic [DEPTH_W-1:0] clamp_pd(input logic [DEPTH_W-1:0] p);
        if (int'(p) < PD_MIN) return DEPTH_W'(PD_MIN);
        if (int'(p) > PD_MAX) return DEPTH_W'(PD_MAX);
        return p;
    endfunction

`ifdef ADC_PIPE_PARITY_EN
    function automatic logic [7:0] chan_parity(input logic [95:0] w);
        logic [7:0] p;
        for (int c = 0; c < 8; c++) p[c] = ^w[c*12 +: 12];
        return p;
    endfunction
    assign wdata = {chan_parity(DIN), DIN};
`else
    assign wdata = DIN;
`endif

    // NOTE: combinational controls assign every output unconditionally, so no latch can form.
    always_comb begin
        trig = L1A && (wstate == RUN);
        pop  = (rstate == RIDLE) && (q_cnt != '0);
        full = (q_cnt - QCNT_W'(pop)) == QCNT_W'(QDEPTH);
        push = trig && !full;
        we   = (wstate != IDLE) && !RESTART && !RST;
    end

    assign BUSY = (q_cnt != '0) || (rstate == READ) || rd_v || DVALID;

    // NOTE: storage arrays carry no reset; only their control state is reset.
    always_ff @(posedge CLK) begin
        if (we) mem[wptr] <= wdata;
        rdata <= mem[raddr];
        if (push && !RESTART && !RST) q_mem[q_wr] <= wptr - pd_lat;
    end

    // NOTE: all clocked state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wstate   <= IDLE;
            wptr     <= '0;
            fill_cnt <= '0;
            pd_lat   <= DEPTH_W'(PD_MIN);
            PIPE_RDY <= 1'b0;
        end else if (RESTART) begin
            wstate   <= FILL;
            wptr     <= '0;
            fill_cnt <= '0;
            pd_lat   <= clamp_pd(PDEPTH);
            PIPE_RDY <= 1'b0;
        end else begin
            PIPE_RDY <= (wstate == RUN);
            case (wstate)
                FILL: begin
                    wptr     <= wptr + 1'b1;
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == pd_lat - 1'b1) wstate <= RUN;
                end
                RUN:     wptr <= wptr + 1'b1;
                default: wstate <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || RESTART) begin
            q_rd    <= '0;
            q_wr    <= '0;
            q_cnt   <= '0;
            rstate  <= RIDLE;
            raddr   <= '0;
            rcnt    <= '0;
            rd_v    <= 1'b0;
            DVALID  <= 1'b0;
            OVFL    <= 1'b0;
            PAR_ERR <= 1'b0;
            if (RST) begin
                DOUT    <= '0;
                EVT_CNT <= '0;
            end
        end else begin
            if (push) begin
                q_wr    <= q_wr + 1'b1;
                EVT_CNT <= EVT_CNT + 12'd1;
            end
            if (trig && full) OVFL <= 1'b1;
            q_cnt <= q_cnt + QCNT_W'(push) - QCNT_W'(pop);
            case (rstate)
                RIDLE: if (pop) begin
                    raddr  <= q_mem[q_rd];
                    q_rd   <= q_rd + 1'b1;
                    rcnt   <= '0;
                    rstate <= READ;
                end
                default: begin
                    raddr <= raddr + 1'b1;
                    rcnt  <= rcnt + 1'b1;
                    if (rcnt == CNT_W'(NSAMP - 1)) rstate <= RIDLE;
                end
            endcase
            // Two-stage output: RAM read register, then the DOUT register.
            rd_v   <= (rstate == READ);
            DVALID <= rd_v;
            if (rd_v) DOUT <= rdata[95:0];
`ifdef ADC_PIPE_PARITY_EN
            if (rd_v && (chan_parity(rdata[95:0]) != rdata[103:96])) PAR_ERR <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_adc_daq_pipeline.sv
// Bench for adc_daq_pipeline: directed scenarios with random DIN/L1A, checked against an event-level model.
// Honours ADC_PIPE_PARITY_EN for the expected PAR_ERR behaviour.
module tb_adc_daq_pipeline;
    localparam int NSAMP  = 8;
    localparam int PD_MIN = NSAMP + 2;
    localparam int PD_MAX = 256 - 5 * NSAMP;
`ifdef ADC_PIPE_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        CLK = 1'b0, RST, RESTART, L1A;
    logic [95:0] DIN, DOUT;
    logic [7:0]  PDEPTH;
    logic        DVALID, PIPE_RDY, BUSY, OVFL, PAR_ERR;
    logic [11:0] EVT_CNT;

    adc_daq_pipeline dut (
        .CLK(CLK), .RST(RST), .RESTART(RESTART), .DIN(DIN), .PDEPTH(PDEPTH), .L1A(L1A),
        .DOUT(DOUT), .DVALID(DVALID), .PIPE_RDY(PIPE_RDY), .BUSY(BUSY), .OVFL(OVFL),
        .EVT_CNT(EVT_CNT), .PAR_ERR(PAR_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {int e; int src;} word_t;

    int          vectors = 0, miscompares = 0;
    int          edge_n = 0;
    logic [95:0] din_at [int];
    logic [95:0] cap [int];
    logic        par_at [int];
    bit          inc_mode = 1'b1;
    logic [95:0] din_cnt = '0;

    // Reference model: event timing and queue occupancy derived from latency/gap/depth rules.
    bit    restarted = 1'b0;
    int    r_edge, pd_m, run_edge, last_end = -100, evt_m = 0;
    bit    ovfl_m = 1'b0;
    int    pop_q [$];
    word_t exp_words [$];

    always @(negedge CLK) begin
        if (!RST && DVALID) begin
            cap[edge_n]    = DOUT;
            par_at[edge_n] = PAR_ERR;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_l1a(input int e);
        int first;
        if (!restarted || e < run_edge) return;
        while (pop_q.size() > 0 && pop_q[0] <= e) void'(pop_q.pop_front());
        if (pop_q.size() >= 4) begin
            ovfl_m = 1'b1;
            return;
        end
        evt_m++;
        first    = (e + 3 > last_end + 2) ? e + 3 : last_end + 2;
        last_end = first + NSAMP - 1;
        pop_q.push_back(first - 2);
        for (int k = 0; k < NSAMP; k++) exp_words.push_back('{first + k, e - pd_m + k});
    endtask

    task automatic model_restart(input int e);
        word_t keep [$];
        restarted = 1'b1;
        r_edge    = e;
        pd_m      = (int'(PDEPTH) < PD_MIN) ? PD_MIN : (int'(PDEPTH) > PD_MAX) ? PD_MAX : int'(PDEPTH);
        run_edge  = e + pd_m + 1;
        pop_q.delete();
        last_end  = -100;
        ovfl_m    = 1'b0;
        foreach (exp_words[i]) if (exp_words[i].e < e) keep.push_back(exp_words[i]);
        exp_words = keep;
    endtask

    task automatic step(input bit l, input bit rs);
        int e = edge_n + 1;
        L1A     = l;
        RESTART = rs;
        if (inc_mode) begin
            DIN     = din_cnt;
            din_cnt = din_cnt + 96'd1;
        end else begin
            DIN = {$urandom(), $urandom(), $urandom()};
        end
        din_at[e] = DIN;
        if (RST) begin
            restarted = 1'b0; evt_m = 0; ovfl_m = 1'b0; last_end = -100;
            pop_q.delete(); exp_words.delete();
        end else if (rs) model_restart(e);
        else if (l) model_l1a(e);
        @(posedge CLK);
        #1;
        edge_n  = e;
        L1A     = 1'b0;
        RESTART = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic step_to(input int e);
        while (edge_n < e - 1) step(1'b0, 1'b0);
    endtask

    task automatic ready_check(input string tag);
        step_to(run_edge);
        chk({tag, "_before"}, PIPE_RDY, 1'b0);
        step(1'b0, 1'b0);
        chk(tag, PIPE_RDY, 1'b1);
    endtask

    task automatic verify(input string tag);
        foreach (exp_words[i])
            chk(tag, cap.exists(exp_words[i].e) ? cap[exp_words[i].e] : 96'bx, din_at[exp_words[i].src]);
        chk({tag, "_count"}, cap.num(), exp_words.size());
        cap.delete();
        par_at.delete();
        exp_words.delete();
    endtask

    initial begin
        int t, s;
        logic [7:0] pa;
        RST = 1'b1; RESTART = 1'b0; L1A = 1'b0; PDEPTH = 8'd20; DIN = '0;
        idle(2);
        RST = 1'b0;
        chk("rst_dout", DOUT, '0);
        chk("rst_dvalid", DVALID, 1'b0);
        chk("rst_pipe_rdy", PIPE_RDY, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ovfl", OVFL, 1'b0);
        chk("rst_evt_cnt", EVT_CNT, '0);
        chk("rst_par_err", PAR_ERR, 1'b0);
        step(1'b1, 1'b0);
        idle(5);
        chk("idle_l1a_ignored", EVT_CNT, '0);

        // Basic event with incrementing DIN and PDEPTH=20.
        step(1'b0, 1'b1);
        ready_check("pipe_rdy_pd20");
        step(1'b1, 1'b0);
        idle(14);
        verify("evt1_word");
        chk("evt1_evt_cnt", EVT_CNT, 12'(evt_m));

        // Burst of five L1As while a readout is in progress: the fifth overflows.
        step(1'b1, 1'b0);
        chk("busy_after_l1a", BUSY, 1'b1);
        idle(2);
        repeat (5) step(1'b1, 1'b0);
        chk("ovfl_set", OVFL, ovfl_m);
        idle(60);
        verify("burst_word");
        chk("burst_evt_cnt", EVT_CNT, 12'(evt_m));
        chk("burst_ovfl_sticky", OVFL, 1'b1);
        chk("burst_busy_drained", BUSY, 1'b0);

        // RESTART during the 4th DVALID word aborts the readout.
        step(1'b1, 1'b0);
        t = edge_n;
        step_to(t + 7);
        step(1'b0, 1'b1);
        chk("abort_dvalid", DVALID, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_ovfl", OVFL, 1'b0);
        chk("abort_pipe_rdy", PIPE_RDY, 1'b0);
        step(1'b1, 1'b0);
        idle(3);
        chk("fill_l1a_ignored", EVT_CNT, 12'(evt_m));
        ready_check("pipe_rdy_refill");
        verify("abort_word");

        // Full queue with a coincident pop: the L1A at the pop cycle is accepted.
        step(1'b1, 1'b0);
        t = edge_n;
        repeat (4) step(1'b1, 1'b0);
        step_to(t + 10);
        step(1'b1, 1'b0);
        chk("coinc_ovfl", OVFL, 1'b0);
        idle(60);
        verify("coinc_word");
        chk("coinc_evt_cnt", EVT_CNT, 12'(evt_m));

        // Low clamp (3 -> 10) with read across the buffer wrap, then random L1A spacing.
        inc_mode = 1'b0;
        PDEPTH = 8'd3;
        step(1'b0, 1'b1);
        ready_check("pipe_rdy_pd3");
        step_to(r_edge + 261);
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 14));
            step(1'b1, 1'b0);
        end
        idle(90);
        verify("rand_word");
        chk("rand_ovfl", OVFL, ovfl_m);
        chk("rand_evt_cnt", EVT_CNT, 12'(evt_m));

        // High clamp (250 -> 216) with read across the buffer wrap.
        PDEPTH = 8'd250;
        step(1'b0, 1'b1);
        ready_check("pipe_rdy_pd250");
        step_to(r_edge + 469);
        step(1'b1, 1'b0);
        idle(16);
        verify("pd250_word");

        // Corrupt bit 5 of the 4th word of the next event.
        idle(3);
        t  = edge_n + 1;
        s  = t - pd_m + 3;
        pa = 8'(s - r_edge - 1);
        dut.mem[pa][5] = ~dut.mem[pa][5];
        din_at[s] = din_at[s] ^ 96'h20;
        chk("par_before", PAR_ERR, 1'b0);
        step(1'b1, 1'b0);
        idle(16);
        chk("par_prev_word", par_at.exists(t + 5) ? par_at[t + 5] : 1'bx, 1'b0);
        chk("par_bad_word", par_at.exists(t + 6) ? par_at[t + 6] : 1'bx, PAR_ON);
        verify("par_word");
        chk("par_sticky", PAR_ERR, PAR_ON);
        step(1'b0, 1'b1);
        chk("par_cleared", PAR_ERR, 1'b0);
        chk("final_evt_cnt", EVT_CNT, 12'(evt_m));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
